// File: rtl/apb_master_req_bridge.sv
// Per-master APB request bridge: queues paired address/write-data requests in a FIFO and
// replays each as an APB SETUP/ACCESS transfer, returning the result on a response channel.
module apb_master_req_bridge #(
  parameter int unsigned ADDR_WIDTH     = 16,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned SLAVE_ID_WIDTH = 2,
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter int unsigned CNT_WIDTH      = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                      I_PCLK,
  input  logic                      I_PRESET,
  input  logic [ADDR_WIDTH-1:0]     I_PADDR,
  input  logic                      I_PADDR_VALID,
  output logic                      O_PADDR_READY,
  input  logic                      I_PWRITE,
  input  logic [SLAVE_ID_WIDTH-1:0] I_PSLAVE_ID,
  input  logic [DATA_WIDTH-1:0]     I_PWDATA,
  input  logic                      I_PWDATA_VALID,
  output logic                      O_PWDATA_READY,
  output logic                      O_PSEL,
  output logic                      O_PENABLE,
  output logic [ADDR_WIDTH-1:0]     O_PADDR,
  output logic                      O_PWRITE,
  output logic [DATA_WIDTH-1:0]     O_PWDATA,
  output logic [SLAVE_ID_WIDTH-1:0] O_PSLAVE_ID,
  input  logic                      I_PREADY,
  input  logic [DATA_WIDTH-1:0]     I_PRDATA,
  input  logic                      I_PSLVERR,
  output logic                      O_RSP_VALID,
  output logic [DATA_WIDTH-1:0]     O_RSP_DATA,
  output logic                      O_RSP_WRITE,
  output logic                      O_RSP_ERR,
  input  logic                      I_RSP_READY,
  output logic [CNT_WIDTH-1:0]      O_FIFO_COUNT
);

  localparam int unsigned PTR_WIDTH = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {StIdle, StSetup, StAccess, StResp} state_e;

  state_e state_q;

  logic [ADDR_WIDTH-1:0]     mem_addr  [FIFO_DEPTH];
  logic                      mem_write [FIFO_DEPTH];
  logic [SLAVE_ID_WIDTH-1:0] mem_sid   [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0]     mem_wdata [FIFO_DEPTH];

  logic [PTR_WIDTH-1:0] wr_ptr_q;
  logic [PTR_WIDTH-1:0] rd_ptr_q;
  logic [CNT_WIDTH-1:0] count_q;

  logic full;
  logic push;
  logic pop;

  assign full           = (count_q == CNT_WIDTH'(FIFO_DEPTH));
  // Address and write data are accepted together; a read never consumes write data.
  assign O_PADDR_READY  = !full && (!I_PWRITE || I_PWDATA_VALID);
  assign O_PWDATA_READY = !full && I_PADDR_VALID && I_PWRITE;
  assign push           = I_PADDR_VALID && O_PADDR_READY;
  assign pop            = (state_q == StIdle) && (count_q != '0);
  assign O_FIFO_COUNT   = count_q;

  always_ff @(posedge I_PCLK) begin
    if (push) begin
      mem_addr[wr_ptr_q]  <= I_PADDR;
      mem_write[wr_ptr_q] <= I_PWRITE;
      mem_sid[wr_ptr_q]   <= I_PSLAVE_ID;
      mem_wdata[wr_ptr_q] <= I_PWRITE ? I_PWDATA : '0;
    end
  end

  always_ff @(posedge I_PCLK or posedge I_PRESET) begin
    if (I_PRESET) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_WIDTH'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_WIDTH'(1);
      unique case ({push, pop})
        2'b10:   count_q <= count_q + CNT_WIDTH'(1);
        2'b01:   count_q <= count_q - CNT_WIDTH'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge I_PCLK or posedge I_PRESET) begin
    if (I_PRESET) begin
      state_q     <= StIdle;
      O_PSEL      <= 1'b0;
      O_PENABLE   <= 1'b0;
      O_PADDR     <= '0;
      O_PWRITE    <= 1'b0;
      O_PWDATA    <= '0;
      O_PSLAVE_ID <= '0;
      O_RSP_VALID <= 1'b0;
      O_RSP_DATA  <= '0;
      O_RSP_WRITE <= 1'b0;
      O_RSP_ERR   <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (pop) begin
            O_PADDR     <= mem_addr[rd_ptr_q];
            O_PWRITE    <= mem_write[rd_ptr_q];
            O_PSLAVE_ID <= mem_sid[rd_ptr_q];
            O_PWDATA    <= mem_wdata[rd_ptr_q];
            O_PSEL      <= 1'b1;
            state_q     <= StSetup;
          end
        end
        StSetup: begin
          O_PENABLE <= 1'b1;
          state_q   <= StAccess;
        end
        StAccess: begin
          // Address/data stay frozen here until the slave completes.
          if (I_PREADY) begin
            O_RSP_DATA  <= O_PWRITE ? '0 : I_PRDATA;
            O_RSP_ERR   <= I_PSLVERR;
            O_RSP_WRITE <= O_PWRITE;
            O_RSP_VALID <= 1'b1;
            O_PSEL      <= 1'b0;
            O_PENABLE   <= 1'b0;
            state_q     <= StResp;
          end
        end
        StResp: begin
          if (I_RSP_READY) begin
            O_RSP_VALID <= 1'b0;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
